// File: rtl/spi_burst_master.sv
// SPI mode-0 burst master: command, address, then 1..MAX_LEN data bytes, MSB first.
// SCLK divider and nCS setup/hold/deselect-gap timing are set by parameters.
module spi_burst_master #(
  parameter int HALF_DIV = 7,
  parameter int CSS_CYC  = 10,
  parameter int CSH_CYC  = 3,
  parameter int GAP_CYC  = 5,
  parameter int MAX_LEN  = 8,
  parameter int LEN_W    = 4
) (
  input  logic             ck,
  input  logic             reset,
  input  logic             start,
  input  logic             rw,
  input  logic [7:0]       addr,
  input  logic [LEN_W-1:0] len,
  input  logic [7:0]       wdata,
  output logic             wdata_req,
  output logic [7:0]       rdata,
  output logic             rdata_valid,
  output logic             busy,
  output logic             done,
  output logic             nCS,
  output logic             sclk,
  output logic             mosi,
  input  logic             miso
);

  localparam logic [7:0] CMD_READ  = 8'h0B;
  localparam logic [7:0] CMD_WRITE = 8'h0A;
  localparam int PH_AB  = (HALF_DIV > CSS_CYC) ? HALF_DIV : CSS_CYC;
  localparam int PH_CD  = (CSH_CYC > GAP_CYC) ? CSH_CYC : GAP_CYC;
  localparam int PH_MAX = (PH_AB > PH_CD) ? PH_AB : PH_CD;
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam int CNT_W  = $clog2(MAX_LEN + 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CS_SETUP,
    S_SHIFT,
    S_CS_HOLD,
    S_CS_GAP
  } state_e;

  state_e           state_q, state_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [2:0]       bit_q, bit_d;
  logic [CNT_W-1:0] byte_q, byte_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             rw_q, rw_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       tx_q, tx_d;
  logic [6:0]       rx_q, rx_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             rdata_valid_q, rdata_valid_d;
  logic             wdata_req_q, wdata_req_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ncs_q, ncs_d;
  logic             sclk_q, sclk_d;
  logic             mosi_q, mosi_d;

  logic [CNT_W-1:0] len_eff;
  logic [7:0]       load_byte;

  // A zero length still moves one byte; oversize requests are clamped.
  always_comb begin
    if (len == '0) begin
      len_eff = CNT_W'(1);
    end else if (32'(len) > 32'(MAX_LEN)) begin
      len_eff = CNT_W'(MAX_LEN);
    end else begin
      len_eff = CNT_W'(len);
    end
  end

  always_comb begin
    // NOTE: every next-state signal gets a default first, so no path through the case infers a latch.
    state_d       = state_q;
    phase_d       = phase_q;
    bit_d         = bit_q;
    byte_d        = byte_q;
    len_d         = len_q;
    rw_d          = rw_q;
    addr_d        = addr_q;
    tx_d          = tx_q;
    rx_d          = rx_q;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    wdata_req_d   = 1'b0;
    done_d        = 1'b0;
    busy_d        = busy_q;
    ncs_d         = ncs_q;
    sclk_d        = sclk_q;
    mosi_d        = mosi_q;
    load_byte     = 8'h00;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CS_SETUP;
          rw_d    = rw;
          addr_d  = addr;
          len_d   = len_eff;
          tx_d    = rw ? CMD_READ : CMD_WRITE;
          phase_d = '0;
          bit_d   = '0;
          byte_d  = '0;
          busy_d  = 1'b1;
          ncs_d   = 1'b0;
        end
      end

      S_CS_SETUP: begin
        if (phase_q == PH_W'(CSS_CYC - 1)) begin
          state_d = S_SHIFT;
          phase_d = '0;
          mosi_d  = tx_q[7];
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end

      S_SHIFT: begin
        if (phase_q != PH_W'(HALF_DIV - 1)) begin
          phase_d = phase_q + PH_W'(1);
        end else begin
          phase_d = '0;
          sclk_d  = ~sclk_q;
          if (!sclk_q) begin
            // Rising SCLK edge: sample miso; the 8th sample of a data byte completes it.
            rx_d = {rx_q[5:0], miso};
            if (bit_q == 3'd7 && rw_q && byte_q >= CNT_W'(2)) begin
              rdata_d       = {rx_q, miso};
              rdata_valid_d = 1'b1;
            end
          end else if (bit_q != 3'd7) begin
            bit_d  = bit_q + 3'd1;
            tx_d   = {tx_q[6:0], 1'b0};
            mosi_d = tx_q[6];
          end else if (byte_q == len_q + CNT_W'(1)) begin
            state_d = S_CS_HOLD;
            bit_d   = '0;
            mosi_d  = 1'b0;
          end else begin
            // Byte boundary: address after the command, then write data or zeros for reads.
            bit_d  = '0;
            byte_d = byte_q + CNT_W'(1);
            if (byte_q == '0) begin
              load_byte = addr_q;
            end else if (!rw_q) begin
              load_byte   = wdata;
              wdata_req_d = 1'b1;
            end
            tx_d   = load_byte;
            mosi_d = load_byte[7];
          end
        end
      end

      S_CS_HOLD: begin
        if (phase_q == PH_W'(CSH_CYC - 1)) begin
          state_d = S_CS_GAP;
          phase_d = '0;
          ncs_d   = 1'b1;
          done_d  = 1'b1;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end

      S_CS_GAP: begin
        if (phase_q == PH_W'(GAP_CYC - 1)) begin
          state_d = S_IDLE;
          phase_d = '0;
          byte_d  = '0;
          busy_d  = 1'b0;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge ck) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      phase_q       <= '0;
      bit_q         <= '0;
      byte_q        <= '0;
      len_q         <= '0;
      rw_q          <= 1'b0;
      addr_q        <= '0;
      tx_q          <= '0;
      rx_q          <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      wdata_req_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      ncs_q         <= 1'b1;
      sclk_q        <= 1'b0;
      mosi_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      bit_q         <= bit_d;
      byte_q        <= byte_d;
      len_q         <= len_d;
      rw_q          <= rw_d;
      addr_q        <= addr_d;
      tx_q          <= tx_d;
      rx_q          <= rx_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      wdata_req_q   <= wdata_req_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      ncs_q         <= ncs_d;
      sclk_q        <= sclk_d;
      mosi_q        <= mosi_d;
    end
  end

  assign wdata_req   = wdata_req_q;
  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign nCS         = ncs_q;
  assign sclk        = sclk_q;
  assign mosi        = mosi_q;

endmodule

// File: tb/tb_spi_burst_master.sv
// Bench for spi_burst_master: table of frames, SPI slave/monitor, byte scoreboard,
// plus hand-written reset-abort and start-while-busy sequences.
`timescale 1ns/1ps
module tb_spi_burst_master;
  localparam int HALF_DIV = 2;
  localparam int CSS_CYC  = 2;
  localparam int CSH_CYC  = 1;
  localparam int GAP_CYC  = 2;
  localparam int MAX_LEN  = 8;
  localparam int LEN_W    = 4;
  localparam int BYTE_CYC = 2 * HALF_DIV * 8;

  logic             ck = 1'b0;
  logic             reset, start, rw;
  logic [7:0]       addr;
  logic [LEN_W-1:0] len;
  logic [7:0]       wdata = 8'hEE;
  logic             miso = 1'b0;
  logic             wdata_req, rdata_valid, busy, done, nCS, sclk, mosi;
  logic [7:0]       rdata;

  always #5 ck = ~ck;

  spi_burst_master #(
    .HALF_DIV(HALF_DIV), .CSS_CYC(CSS_CYC), .CSH_CYC(CSH_CYC),
    .GAP_CYC(GAP_CYC), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)
  ) dut (
    .ck(ck), .reset(reset), .start(start), .rw(rw), .addr(addr), .len(len),
    .wdata(wdata), .wdata_req(wdata_req), .rdata(rdata), .rdata_valid(rdata_valid),
    .busy(busy), .done(done), .nCS(nCS), .sclk(sclk), .mosi(mosi), .miso(miso)
  );

  typedef struct {
    logic             rw;
    logic [7:0]       addr;
    logic [LEN_W-1:0] len;
    logic [63:0]      data;     // byte k = data[8k+7:8k]; slave reply or write data
    int               n;        // expected effective data bytes
    int               rises;    // expected SCLK rising edges
    int               ncs_low;  // expected nCS-low cycles
    logic             poke;     // pulse start again while busy
  } vec_t;

  vec_t vecs[6];
  int   errors = 0;
  int   checks = 0;

  logic [63:0] tb_data = '0;
  logic [7:0]  exp_mosi[$];
  logic [7:0]  exp_rd[$];

  // Monitor / slave state, written only by the negedge process below.
  int         cyc = 0, f_rises = 0, f_ncs_low = 0, f_rv = 0, f_wr = 0, wd_idx = 0;
  int         done_cnt = 0, ncs_falls = 0, viol = 0, gap_err = 0;
  int         last_rv = -1, done_cyc = 0, busy_lat = -1, m_bi = 0;
  logic       ncs_prev = 1'b1, sclk_prev = 1'b0, mosi_prev = 1'b0, busy_prev = 1'b0;
  logic [7:0] sh = '0;
  logic [7:0] mon_mosi[$];
  logic [7:0] mon_rd[$];

  always @(negedge ck) begin
    cyc++;
    if (ncs_prev === 1'b1 && nCS === 1'b0) begin
      ncs_falls++;
      f_rises = 0; f_ncs_low = 0; f_rv = 0; f_wr = 0; wd_idx = 0;
      gap_err = 0; last_rv = -1; busy_lat = -1;
    end
    if (nCS === 1'b0) f_ncs_low++;
    if (nCS === 1'b1 && sclk !== 1'b0) viol++;
    if (sclk_prev === 1'b1 && sclk === 1'b1 && mosi !== mosi_prev) viol++;
    if (sclk_prev === 1'b0 && sclk === 1'b1) begin
      sh = {sh[6:0], mosi};
      f_rises++;
      if (f_rises % 8 == 0) mon_mosi.push_back(sh);
    end
    if (rdata_valid === 1'b1) begin
      f_rv++;
      mon_rd.push_back(rdata);
      if (last_rv >= 0 && cyc - last_rv != BYTE_CYC) gap_err++;
      last_rv = cyc;
    end
    if (wdata_req === 1'b1) begin
      f_wr++;
      wd_idx++;
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (busy_prev === 1'b1 && busy === 1'b0) busy_lat = cyc - done_cyc;
    // Slave presents the next bit after each rising edge; cmd/addr slots carry noise.
    m_bi = f_rises / 8 - 2;
    if (nCS === 1'b0 && m_bi >= 0 && m_bi < 8) miso = tb_data[8 * m_bi + 7 - (f_rises % 8)];
    else miso = 1'($urandom_range(0, 1));
    wdata = (wd_idx < 8) ? tb_data[8 * wd_idx +: 8] : 8'hEE;
    ncs_prev  = nCS;
    sclk_prev = sclk;
    mosi_prev = mosi;
    busy_prev = busy;
  end

  task automatic tick();
    @(negedge ck);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_frame(input vec_t v);
    logic [7:0] e;
    int mb, rb, db, fb, k, idx;
    tb_data = v.data;
    exp_mosi.push_back(v.rw ? 8'h0B : 8'h0A);
    exp_mosi.push_back(v.addr);
    for (int i = 0; i < v.n; i++) begin
      exp_mosi.push_back(v.rw ? 8'h00 : v.data[8 * i +: 8]);
      if (v.rw) exp_rd.push_back(v.data[8 * i +: 8]);
    end
    mb = mon_mosi.size(); rb = mon_rd.size(); db = done_cnt; fb = ncs_falls;
    rw = v.rw; addr = v.addr; len = v.len; start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_accept", busy, 1'b1);
    check("ncs_after_accept", nCS, 1'b0);
    if (v.poke) begin
      repeat (30) tick();
      addr = 8'h55; rw = ~v.rw; start = 1'b1;
      tick();
      start = 1'b0; addr = v.addr; rw = v.rw;
    end
    k = 0;
    while (done_cnt == db && k < 4000) begin tick(); k++; end
    k = 0;
    while (busy !== 1'b0 && k < 100) begin tick(); k++; end
    repeat (8) tick();
    check("done_pulses", done_cnt - db, 1);
    check("ncs_falls", ncs_falls - fb, 1);
    check("sclk_rises", f_rises, v.rises);
    check("ncs_low_cycles", f_ncs_low, v.ncs_low);
    check("busy_drop_after_done", busy_lat, GAP_CYC);
    check("rdata_valid_pulses", f_rv, v.rw ? v.n : 0);
    check("wdata_req_pulses", f_wr, v.rw ? 0 : v.n);
    check("rdata_spacing_errs", gap_err, 0);
    check("mosi_byte_count", mon_mosi.size() - mb, 2 + v.n);
    idx = mb;
    while (exp_mosi.size() > 0) begin
      e = exp_mosi.pop_front();
      if (idx < mon_mosi.size()) check($sformatf("mosi_byte_%0d", idx - mb), mon_mosi[idx], e);
      idx++;
    end
    idx = rb;
    while (exp_rd.size() > 0) begin
      e = exp_rd.pop_front();
      if (idx < mon_rd.size()) check($sformatf("rdata_%0d", idx - rb), mon_rd[idx], e);
      idx++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int k, db;
    vecs[0] = '{1'b1, 8'h00, 4'd1,  64'h00000000000000AD, 1, 24, 99,  1'b0};
    vecs[1] = '{1'b1, 8'h08, 4'd3,  64'h0000000000563412, 3, 40, 163, 1'b0};
    vecs[2] = '{1'b0, 8'h2D, 4'd2,  64'h0000000000000002, 2, 32, 131, 1'b0};
    vecs[3] = '{1'b1, 8'h1A, 4'd0,  64'h00000000000077C3, 1, 24, 99,  1'b0};
    vecs[4] = '{1'b0, 8'h20, 4'd15, 64'h8877665544332211, 8, 80, 323, 1'b1};
    vecs[5] = '{1'b1, 8'h0B, 4'd1,  64'h000000000000005A, 1, 24, 99,  1'b0};

    reset = 1'b0; start = 1'b0; rw = 1'b0; addr = 8'h00; len = '0;
    repeat (3) tick();
    check("reset_ncs", nCS, 1'b1);
    check("reset_sclk", sclk, 1'b0);
    check("reset_mosi", mosi, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_rdata", rdata, 8'h00);
    check("reset_rdata_valid", rdata_valid, 1'b0);
    check("reset_wdata_req", wdata_req, 1'b0);
    reset = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < 5; i++) run_frame(vecs[i]);

    // Reset asserted mid-frame, during data bit 3 of the first data byte.
    tb_data = 64'h000000000000F0F0;
    rw = 1'b1; addr = 8'h33; len = 4'd2; start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    while (f_rises < 19 && k < 2000) begin tick(); k++; end
    repeat (3) tick();
    check("abort_point_rises", f_rises, 19);
    db = done_cnt;
    reset = 1'b0;
    tick();
    check("abort_ncs", nCS, 1'b1);
    check("abort_sclk", sclk, 1'b0);
    check("abort_busy", busy, 1'b0);
    tick();
    reset = 1'b1;
    repeat (40) tick();
    check("abort_no_done", done_cnt - db, 0);
    check("abort_no_rdata_valid", f_rv, 0);
    check("abort_ncs_stays_high", nCS, 1'b1);

    run_frame(vecs[5]);

    check("protocol_violations", viol, 0);
    check("total_done", done_cnt, 6);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
